// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int ADDR_W_DEF = 30;
   localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: data side wins unless the instruction side has waited
// through STARVE_MAX consecutive data grants.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 3,
   parameter int STREAK_W   = 2
) (
   input  logic                i_req,
   input  logic                d_req,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_valid,
   output logic                grant_owner
);

   logic i_forced;

   assign i_forced = i_req && (streak >= STREAK_W'(STARVE_MAX));

   always_comb begin
      grant_valid = i_req | d_req;
      grant_owner = OWN_I;
      if (d_req && !i_forced) begin
         grant_owner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-side and D-side miss requests onto one slow memory port,
// one outstanding access at a time, answering each with a one-cycle ack.
//
// state | meaning
// IDLE  | no access in flight; grant decision made on incoming requests
// BUSY  | latched request driven to memory, waiting for mem_ready
// RESP  | one-cycle ack to the owner; requests not sampled
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int STREAK_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_MAX);

   state_e              state_q,   state_d;
   logic                owner_q,   owner_d;
   logic                wen_q,     wen_d;
   logic [ADDR_W-1:0]   addr_q,    addr_d;
   logic [DATA_W-1:0]   wdata_q,   wdata_d;
   logic [STREAK_W-1:0] streak_q,  streak_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   logic grant_valid;
   logic grant_owner;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .STREAK_W   (STREAK_W)
   ) u_pick (
      .i_req       (i_req),
      .d_req       (d_req),
      .streak      (streak_q),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      streak_d  = streak_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d = grant_owner;
               state_d = BUSY;
               if (grant_owner == OWN_D) begin
                  addr_d  = d_addr;
                  wen_d   = d_wen;
                  wdata_d = d_wdata;
                  // streak counts D grants that made a waiting I request wait
                  if (i_req) begin
                     streak_d = (streak_q == STREAK_SAT) ? streak_q
                                                         : streak_q + STREAK_W'(1);
                  end else begin
                     streak_d = '0;
                  end
               end else begin
                  addr_d   = i_addr;
                  wen_d    = 1'b0;
                  wdata_d  = '0;
                  streak_d = '0;
               end
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_d = RESP;
               if (owner_q == OWN_I) begin
                  i_rdata_d = mem_rdata;
               end else if (!wen_q) begin
                  d_rdata_d = mem_rdata;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_I;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         streak_q  <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         streak_q  <= streak_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign mem_read  = (state_q == BUSY) && ((owner_q == OWN_I) || !wen_q);
   assign mem_write = (state_q == BUSY) && (owner_q == OWN_D) && wen_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_ack     = (state_q == RESP) && (owner_q == OWN_I);
   assign d_ack     = (state_q == RESP) && (owner_q == OWN_D);
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, fairness, reset abort and
// spurious mem_ready, all against hand-computed expectations.
module tb_mem_arbiter;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_wen;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_wen     (d_wen),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rd"},   64'(mem_read),  64'd0);
      chk({tag, "_wr"},   64'(mem_write), 64'd0);
      chk({tag, "_iack"}, 64'(i_ack),     64'd0);
      chk({tag, "_dack"}, 64'(d_ack),     64'd0);
   endtask

   initial begin
      logic [DATA_W-1:0] exp_i_rdata;
      logic [DATA_W-1:0] exp_d_rdata;
      logic              exp_is_d;
      logic              got_is_d;
      int                budget;

      rst       = 1'b1;
      i_req     = 1'b0;
      i_addr    = '0;
      d_req     = 1'b0;
      d_wen     = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;

      // reset and idle
      tick();
      tick();
      chk_quiet("rst");
      chk("rst_addr",    64'(mem_addr), 64'd0);
      chk("rst_wdata",   mem_wdata,     64'd0);
      chk("rst_irdata",  i_rdata,       64'd0);
      chk("rst_drdata",  d_rdata,       64'd0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_strobe", 64'(mem_read | mem_write), 64'd0);
      end

      // single I read, mem_ready in cycle 3
      i_req  = 1'b1;
      i_addr = 30'h0000100;
      tick();
      chk("ird_c1_rd",   64'(mem_read),  64'd1);
      chk("ird_c1_wr",   64'(mem_write), 64'd0);
      chk("ird_c1_addr", 64'(mem_addr),  64'h100);
      chk("ird_c1_iack", 64'(i_ack),     64'd0);
      tick();
      chk("ird_c2_rd",   64'(mem_read),  64'd1);
      tick();
      chk("ird_c3_rd",   64'(mem_read),  64'd1);
      mem_ready = 1'b1;
      mem_rdata = 64'hDEADBEEF_01234567;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk("ird_c4_iack",  64'(i_ack),    64'd1);
      chk("ird_c4_rdata", i_rdata,       64'hDEADBEEF_01234567);
      chk("ird_c4_dack",  64'(d_ack),    64'd0);
      chk("ird_c4_rd",    64'(mem_read), 64'd0);
      exp_i_rdata = 64'hDEADBEEF_01234567;
      tick();
      i_req = 1'b0;
      chk("ird_c5_iack", 64'(i_ack), 64'd0);
      chk("ird_c5_dack", 64'(d_ack), 64'd0);

      // D write, mem_ready in cycle 1; garbage on mem_rdata must not land in d_rdata
      d_req   = 1'b1;
      d_wen   = 1'b1;
      d_addr  = 30'h0000040;
      d_wdata = 64'h11223344_55667788;
      tick();
      chk("dwr_c1_wr",    64'(mem_write), 64'd1);
      chk("dwr_c1_rd",    64'(mem_read),  64'd0);
      chk("dwr_c1_addr",  64'(mem_addr),  64'h40);
      chk("dwr_c1_wdata", mem_wdata,      64'h11223344_55667788);
      mem_ready = 1'b1;
      mem_rdata = 64'hBADBADBA_DBADBAD0;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk("dwr_c2_dack",   64'(d_ack),     64'd1);
      chk("dwr_c2_iack",   64'(i_ack),     64'd0);
      chk("dwr_c2_wr",     64'(mem_write), 64'd0);
      chk("dwr_c2_rd",     64'(mem_read),  64'd0);
      chk("dwr_c2_drdata", d_rdata,        64'd0);
      chk("dwr_c2_irdata", i_rdata,        exp_i_rdata);
      tick();
      d_req = 1'b0;
      d_wen = 1'b0;
      chk("dwr_c3_dack", 64'(d_ack), 64'd0);

      // D read, mem_ready in cycle 2
      d_req  = 1'b1;
      d_addr = 30'h0000200;
      tick();
      chk("drd_c1_rd",   64'(mem_read),  64'd1);
      chk("drd_c1_wr",   64'(mem_write), 64'd0);
      chk("drd_c1_addr", 64'(mem_addr),  64'h200);
      tick();
      mem_ready = 1'b1;
      mem_rdata = 64'hCAFEF00D_55AA55AA;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk("drd_c3_dack",   64'(d_ack), 64'd1);
      chk("drd_c3_iack",   64'(i_ack), 64'd0);
      chk("drd_c3_drdata", d_rdata,    64'hCAFEF00D_55AA55AA);
      exp_d_rdata = 64'hCAFEF00D_55AA55AA;
      tick();
      d_req = 1'b0;

      // both requesters held: expect D,D,D,I,D,D,D,I
      i_req  = 1'b1;
      i_addr = 30'h0000111;
      d_req  = 1'b1;
      d_wen  = 1'b0;
      d_addr = 30'h0000222;
      for (int g = 0; g < 8; g++) begin
         exp_is_d = ((g % 4) != 3);
         tick();
         budget = 0;
         while (!(mem_read || mem_write) && budget < 20) begin
            tick();
            budget++;
         end
         if (!(mem_read || mem_write)) begin
            chk("starve_wait", 64'd0, 64'd1);
         end
         got_is_d = (mem_addr == 30'h0000222);
         chk($sformatf("starve_g%0d_owner", g), 64'(got_is_d), 64'(exp_is_d));
         chk($sformatf("starve_g%0d_both", g), 64'(mem_read & mem_write), 64'd0);
         mem_ready = 1'b1;
         mem_rdata = 64'hA000 + 64'(g);
         tick();
         mem_ready = 1'b0;
         mem_rdata = '0;
         chk($sformatf("starve_g%0d_iack", g), 64'(i_ack), 64'(!exp_is_d));
         chk($sformatf("starve_g%0d_dack", g), 64'(d_ack), 64'(exp_is_d));
         if (exp_is_d) begin
            chk($sformatf("starve_g%0d_drdata", g), d_rdata, 64'hA000 + 64'(g));
         end else begin
            chk($sformatf("starve_g%0d_irdata", g), i_rdata, 64'hA000 + 64'(g));
         end
      end
      tick();
      i_req = 1'b0;
      d_req = 1'b0;

      // reset during BUSY abandons the access
      i_req  = 1'b1;
      i_addr = 30'h0000300;
      tick();
      chk("rbusy_c1_rd", 64'(mem_read), 64'd1);
      tick();
      chk("rbusy_c2_rd", 64'(mem_read), 64'd1);
      rst   = 1'b1;
      i_req = 1'b0;
      tick();
      rst = 1'b0;
      chk_quiet("rbusy_after");
      chk("rbusy_addr",   64'(mem_addr), 64'd0);
      chk("rbusy_irdata", i_rdata,       64'd0);
      mem_ready = 1'b1;
      mem_rdata = 64'h5555AAAA_5555AAAA;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk_quiet("rbusy_late");
      chk("rbusy_late_irdata", i_rdata, 64'd0);

      // fresh I read after the abort, mem_ready in cycle 2
      i_req  = 1'b1;
      i_addr = 30'h0000155;
      tick();
      chk("fresh_c1_rd",   64'(mem_read), 64'd1);
      chk("fresh_c1_addr", 64'(mem_addr), 64'h155);
      tick();
      mem_ready = 1'b1;
      mem_rdata = 64'h0F0F0F0F_F0F0F0F0;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk("fresh_c3_iack",   64'(i_ack), 64'd1);
      chk("fresh_c3_dack",   64'(d_ack), 64'd0);
      chk("fresh_c3_irdata", i_rdata,    64'h0F0F0F0F_F0F0F0F0);
      exp_i_rdata = 64'h0F0F0F0F_F0F0F0F0;
      tick();
      i_req = 1'b0;

      // spurious mem_ready in IDLE
      mem_ready = 1'b1;
      mem_rdata = 64'hBAD0BAD0_BAD0BAD0;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      chk_quiet("spur_idle");
      chk("spur_idle_irdata", i_rdata, exp_i_rdata);
      chk("spur_idle_drdata", d_rdata, 64'd0);
      tick();
      chk_quiet("spur_idle2");

      // spurious mem_ready in the RESP cycle
      d_req  = 1'b1;
      d_wen  = 1'b0;
      d_addr = 30'h00002A0;
      tick();
      chk("spur_resp_c1_rd", 64'(mem_read), 64'd1);
      mem_ready = 1'b1;
      mem_rdata = 64'h00000000_00001234;
      tick();
      mem_rdata = 64'hBAD1BAD1_BAD1BAD1;
      chk("spur_resp_c2_dack",   64'(d_ack), 64'd1);
      chk("spur_resp_c2_drdata", d_rdata,    64'h1234);
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      d_req     = 1'b0;
      chk_quiet("spur_resp_c3");
      chk("spur_resp_c3_drdata", d_rdata, 64'h1234);
      chk("spur_resp_c3_irdata", i_rdata, exp_i_rdata);
      tick();
      chk_quiet("spur_resp_c4");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single slow backing-memory port between the instruction-side and data-side miss requesters of the RISCV core. Requests are serialised through a small FSM. The data side has priority, with a bounded-starvation guarantee for the instruction side. Each request is latched, driven to memory until mem_ready, then answered with a one-cycle ack carrying registered read data.

Parameters:
ADDR_W, 30, word-address width (address bits [31:2]).
DATA_W, 64, data width of a memory beat.
STARVE_MAX, 3, maximum consecutive D grants while i_req is pending before I is forced.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
i_req  in  1  instruction-side read request, held until i_ack.
i_addr  in  ADDR_W  instruction read word address, stable while i_req.
i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
i_rdata  out  DATA_W  registered read data for I.
d_req  in  1  data-side request, held until d_ack.
d_wen  in  1  1 = write, 0 = read; stable while d_req.
d_addr  in  ADDR_W  data word address.
d_wdata  in  DATA_W  write data.
d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (reads).
d_rdata  out  DATA_W  registered read data for D.
mem_read  out  1  memory read strobe, held until mem_ready.
mem_write  out  1  memory write strobe, held until mem_ready.
mem_addr  out  ADDR_W  latched request address.
mem_wdata  out  DATA_W  latched write data.
mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
mem_ready  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset (rst=1 at an edge): state IDLE. All outputs 0. Latches and streak counter cleared. Applies mid-transaction: the in-flight access is abandoned, no ack is issued, and the memory shares rst.
- States: IDLE, BUSY, RESP. Register owner: 0 = I, 1 = D.
- IDLE, grant decision:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both: grant D unless streak == STARVE_MAX, in which case grant I.
  - On grant, latch addr, wen and wdata, set owner, go to BUSY.
  - No request: stay in IDLE.
- Streak counter:
  - D grant while i_req is high: streak+1, saturating at STARVE_MAX.
  - Any I grant: streak = 0.
  - D grant while i_req is low: streak = 0.
- BUSY:
  - mem_read = owner==I, or owner==D and wen==0.
  - mem_write = owner==D and wen==1.
  - mem_addr and mem_wdata come from the latches and stay stable throughout BUSY.
  - On mem_ready: capture mem_rdata into the owner's rdata register, drop strobes next cycle, go to RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle; the other ack stays 0.
  - Next state is IDLE; requests are not sampled in RESP.
- Latency: request seen in IDLE at cycle 0 → strobe high in cycles 1..k (mem_ready in cycle k) → ack in cycle k+1. Minimum is 2 cycles (mem_ready in cycle 1).
- Requester contract: req and its fields held until ack; req deasserted or re-presented from the cycle after ack. A request re-presented in the cycle after ack is a new request.
- mem_ready outside BUSY is ignored.
- rdata registers hold their value until overwritten by the next read for that port. d_rdata is not updated on writes.
- Only one memory transaction is outstanding at any time. mem_read and mem_write are never both 1.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - owner constants OWN_I = 0, OWN_D = 1;
  - default ADDR_W and DATA_W.
- One natural sub-module: mem_arb_pick, a combinational grant decision. Inputs: i_req, d_req, streak. Outputs: grant_valid, grant_owner. This keeps the fairness rule unit-testable.
- The FSM, latches and counter stay in mem_arbiter.

Test Plan:
- Reset then idle → all outputs 0. No mem strobe for 10 cycles with no requests.
- Single I read, addr=0x0000100, memory answers mem_ready in cycle 3 with rdata=0xDEADBEEF_01234567 → mem_read=1 in cycles 1-3, mem_addr=0x0000100, i_ack in cycle 4 with i_rdata=0xDEADBEEF_01234567, d_ack never asserted.
- D write, addr=0x0000040, wdata=0x1122334455667788, mem_ready in cycle 1 → mem_write=1 only in cycle 1 with those values, mem_read=0 throughout, d_ack in cycle 2, d_rdata unchanged.
- i_req and d_req held continuously with STARVE_MAX=3 → grant order D,D,D,I,D,D,D,I. No ack from a requester that was not granted.
- rst asserted while in BUSY with mem_read=1 → next cycle all strobes and acks 0 and state IDLE. A late mem_ready is ignored. A fresh i_req is then served normally.
- Spurious mem_ready in IDLE, and in the RESP cycle → no state change, no extra ack, rdata registers unchanged.
